// File: rtl/banco_pkg.sv
// Shared definitions for the register-bank write-back queue: default widths,
// count-width helper and the queued write entry layout.
package banco_pkg;

  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4;

  // Holds 0..DEPTH inclusive, so one bit wider than the pointers.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CW_DEF = cnt_w(DEPTH_DEF);

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } entrada_t;

endpackage

// File: rtl/cola_circular.sv
// Circular entry store with head/tail/count; exposes every slot and its
// occupancy so the parent can search pending writes.
module cola_circular
  import banco_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = AW_DEF + DW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_head_data,
  output logic [PW-1:0] o_head,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_slots [DEPTH],
  output logic [DEPTH-1:0] o_valid
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // DEPTH is a power of two, so pointer wrap is plain PW-bit overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (i_pop)  r_head <= r_head + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_din;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] w_off;
    assign w_off      = PW'(g) - r_head;
    assign o_valid[g] = {1'b0, w_off} < r_count;
    assign o_slots[g] = r_mem[g];
  end

  assign o_head_data = r_mem[r_head];
  assign o_head      = r_head;
  assign o_count     = r_count;

endmodule

// File: rtl/cola_escritura_banco.sv
// Write-back queue in front of the register bank write port: buffers writes,
// drains one per cycle as dir/di/ena and bypasses pending values to reads.
module cola_escritura_banco
  import banco_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          drain_en,
  output logic [AW-1:0] dir,
  output logic [DW-1:0] di,
  output logic          ena,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          byp1_hit,
  output logic          byp2_hit,
  output logic [DW-1:0] byp1_data,
  output logic [DW-1:0] byp2_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int W = AW + DW;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [W-1:0]  w_head_data;
  logic [PW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic [W-1:0]  w_slots [DEPTH];
  logic [DEPTH-1:0] w_valid;

  logic          r_ena;
  logic [AW-1:0] r_dir;
  logic [DW-1:0] r_di;

  // Handshake: a request transfers on any rising edge where wr_valid and
  // wr_ready are both high; wr_ready depends only on the registered count.
  assign wr_ready = w_count < CW'(DEPTH);
  assign w_accept = wr_valid && wr_ready;
  assign w_push   = w_accept && (wr_addr != '0);
  assign w_pop    = (w_count != '0) && drain_en;

  cola_circular #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_cola (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_din       ({wr_addr, wr_data}),
    .i_pop       (w_pop),
    .o_head_data (w_head_data),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_slots     (w_slots),
    .o_valid     (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ena <= 1'b0;
      r_dir <= '0;
      r_di  <= '0;
    end else begin
      r_ena <= w_pop;
      if (w_pop) begin
        r_dir <= w_head_data[W-1 -: AW];
        r_di  <= w_head_data[DW-1:0];
      end
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing;
  // the output stage is older than every queued entry.
  function automatic logic [DW:0] buscar(input logic [AW-1:0] ra);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    if (r_ena && (r_dir == ra)) res = {1'b1, r_di};
    for (int k = 0; k < DEPTH; k++) begin
      idx = w_head + PW'(k);
      if (w_valid[idx] && (w_slots[idx][W-1 -: AW] == ra))
        res = {1'b1, w_slots[idx][DW-1:0]};
    end
    if (ra == '0) res = '0;
    return res;
  endfunction

  always_comb begin
    {byp1_hit, byp1_data} = buscar(ra1);
    {byp2_hit, byp2_data} = buscar(ra2);
  end

  assign ena   = r_ena;
  assign dir   = r_dir;
  assign di    = r_di;
  assign count = w_count;
  assign empty = (w_count == '0) && !r_ena;

endmodule

// File: tb/tb_cola_escritura_banco.sv
// Bench for cola_escritura_banco: directed steps plus random traffic against
// a queue-based reference of pending writes and the bank output stage.
module tb_cola_escritura_banco;
  import banco_pkg::*;

  localparam int DEPTH = DEPTH_DEF;
  localparam int AW    = AW_DEF;
  localparam int DW    = DW_DEF;
  localparam int CW    = CW_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          drain_en = 1'b0;
  logic [AW-1:0] dir;
  logic [DW-1:0] di;
  logic          ena;
  logic [AW-1:0] ra1 = '0;
  logic [AW-1:0] ra2 = '0;
  logic          byp1_hit, byp2_hit;
  logic [DW-1:0] byp1_data, byp2_data;
  logic [CW-1:0] count;
  logic          empty;

  cola_escritura_banco #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .drain_en  (drain_en),
    .dir       (dir),
    .di        (di),
    .ena       (ena),
    .ra1       (ra1),
    .ra2       (ra2),
    .byp1_hit  (byp1_hit),
    .byp2_hit  (byp2_hit),
    .byp1_data (byp1_data),
    .byp2_data (byp2_data),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // Reference: pending writes in arrival order plus the bank output stage.
  logic [AW+DW-1:0] exp_q[$];
  logic             m_ena;
  logic [AW-1:0]    m_dir;
  logic [DW-1:0]    m_di;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ena = 1'b0;
    m_dir = '0;
    m_di  = '0;
  endtask

  function automatic logic [DW:0] byp_model(input logic [AW-1:0] ra);
    entrada_t e;
    if (ra == '0) return '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      e = entrada_t'(exp_q[i]);
      if (e.addr == ra) return {1'b1, e.data};
    end
    if (m_ena && m_dir == ra) return {1'b1, m_di};
    return '0;
  endfunction

  task automatic check_state();
    chk("count",    64'(count),    64'(exp_q.size()));
    chk("wr_ready", 64'(wr_ready), 64'(exp_q.size() < DEPTH));
    chk("empty",    64'(empty),    64'(exp_q.size() == 0 && !m_ena));
    chk("ena",      64'(ena),      64'(m_ena));
    chk("dir",      64'(dir),      64'(m_dir));
    chk("di",       64'(di),       64'(m_di));
  endtask

  // One clock: drive, check bypass before the edge, advance the model, check.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic dr, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    logic [DW:0] b1, b2;
    logic        acc, pop;
    entrada_t    e;
    wr_valid = v; wr_addr = a; wr_data = d; drain_en = dr; ra1 = r1; ra2 = r2;
    #1;
    b1 = byp_model(r1);
    b2 = byp_model(r2);
    chk("byp1_hit",  64'(byp1_hit),  64'(b1[DW]));
    chk("byp1_data", 64'(byp1_data), 64'(b1[DW-1:0]));
    chk("byp2_hit",  64'(byp2_hit),  64'(b2[DW]));
    chk("byp2_data", 64'(byp2_data), 64'(b2[DW-1:0]));
    chk("wr_ready_pre", 64'(wr_ready), 64'(exp_q.size() < DEPTH));
    acc = v && (exp_q.size() < DEPTH);
    pop = dr && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (pop) begin
      e = entrada_t'(exp_q.pop_front());
      m_ena = 1'b1;
      m_dir = e.addr;
      m_di  = e.data;
    end else begin
      m_ena = 1'b0;
    end
    if (acc && a != '0) exp_q.push_back({a, d});
    wr_valid = 1'b0;
    check_state();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_state();
    chk("rst_byp1_hit", 64'(byp1_hit), 64'd0);
    chk("rst_byp2_hit", 64'(byp2_hit), 64'd0);

    // Minimum latency from accept to bank write.
    step(1'b1, 5'd3, 32'hAAAA0001, 1'b1, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    chk("lat_ena", 64'(ena), 64'd1);
    chk("lat_dir", 64'(dir), 64'd3);
    chk("lat_di",  64'(di),  64'hAAAA0001);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    chk("empty_after", 64'(empty), 64'd1);

    // Fill with drain stalled, fifth request refused until space frees.
    for (int i = 1; i <= 5; i++)
      step(1'b1, AW'(i), 32'h100 + 32'(i), 1'b0, AW'(i), 5'd0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(wr_ready), 64'd0);
    step(1'b1, 5'd5, 32'h105, 1'b1, 5'd5, 5'd1);
    chk("full_pop_dir", 64'(dir), 64'd1);
    chk("full_refused_count", 64'(count), 64'd3);
    step(1'b1, 5'd5, 32'h105, 1'b1, 5'd5, 5'd2);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd4);

    // Youngest pending value wins the bypass.
    step(1'b1, 5'd7, 32'h11, 1'b0, 5'd7, 5'd8);
    step(1'b1, 5'd7, 32'h22, 1'b0, 5'd7, 5'd8);
    ra1 = 5'd7; ra2 = 5'd8;
    #1;
    chk("byp_young_hit",  64'(byp1_hit),  64'd1);
    chk("byp_young_data", 64'(byp1_data), 64'h22);
    chk("byp_miss_hit",   64'(byp2_hit),  64'd0);
    chk("byp_miss_data",  64'(byp2_data), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd8);

    // Address 0 handshakes but never enters the queue.
    step(1'b1, 5'd2, 32'h5, 1'b0, 5'd0, 5'd2);
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd2);
    chk("r0_count", 64'(count), 64'd1);
    ra1 = 5'd0;
    #1;
    chk("r0_byp_hit", 64'(byp1_hit), 64'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd2);

    // Random mixed traffic to exercise pointer wrap and ordering.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));

    // Reset with three queued entries and a bank write in flight.
    for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i + 9), $urandom, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd10);
    chk("pre_rst_ena",   64'(ena),   64'd1);
    chk("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b1;
    drain_en = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_ena",   64'(ena),      64'd0);
    chk("rst_count", 64'(count),    64'd0);
    chk("rst_ready", 64'(wr_ready), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
